// File: rtl/frame_checker_32_if.sv
// Xillybus 32-bit write pipe as seen by the FPGA user logic.
// master = host/core side, slave = the receiving user block.
interface frame_checker_32_if;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        wr_open;
    logic        wr_full;

    modport master (output wr_en, output wr_data, output wr_open, input wr_full);
    modport slave  (input wr_en, input wr_data, input wr_open, output wr_full);
endinterface

// File: rtl/frame_checker_32.sv
// Receive-side checker for head/payload/tail test frames on the 32-bit write pipe.
// Keeps saturating good/bad/word-error/abort counters for status readout.
//
// state   | meaning
// --------+---------------------------------------------------------------
// HUNT    | discarding words until a HEAD_WORD is accepted
// PAYLOAD | checking payload word idx against {2*idx-1, 2*idx}
// TAIL    | expecting TAIL_WORD; closes the frame either way
module frame_checker_32 #(
    parameter int          PAYLOAD_WORDS = 24,
    parameter logic [31:0] HEAD_WORD     = 32'hAAAAAAAA,
    parameter logic [31:0] TAIL_WORD     = 32'hF0F0F0F0,
    parameter int          CNT_W         = 32
) (
    input  logic                bus_clk,
    input  logic                rst_n,
    frame_checker_32_if.slave   wr,
    input  logic                clr_stats,
    output logic [CNT_W-1:0]    frame_ok_cnt,
    output logic [CNT_W-1:0]    frame_err_cnt,
    output logic [CNT_W-1:0]    word_err_cnt,
    output logic [CNT_W-1:0]    abort_cnt,
    output logic [7:0]          last_err_idx,
    output logic                frame_done,
    output logic                frame_good,
    output logic                in_sync,
    output logic                led_activity
);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        TAIL    = 2'd2
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_WORDS);

    state_t     state;
    logic [7:0] idx;
    logic       frame_bad;

    logic accept;
    logic abort_hit;
    logic word_err_hit;
    logic ok_hit;
    logic err_hit;

    function automatic logic [31:0] expected_word(input logic [7:0] i);
        logic [15:0] even;
        even = {7'd0, i, 1'b0};
        return {even - 16'd1, even};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // The block never stalls the core; full only flags that we are held in reset.
    assign wr.wr_full = ~rst_n;
    assign accept     = wr.wr_en & ~wr.wr_full;

    always_comb begin
        abort_hit    = 1'b0;
        word_err_hit = 1'b0;
        ok_hit       = 1'b0;
        err_hit      = 1'b0;
        if (!wr.wr_open && state != HUNT) begin
            abort_hit = 1'b1;
        end else if (accept) begin
            if (state == PAYLOAD && wr.wr_data != expected_word(idx)) begin
                word_err_hit = 1'b1;
            end
            if (state == TAIL) begin
                ok_hit  = (wr.wr_data == TAIL_WORD) && !frame_bad;
                err_hit = !((wr.wr_data == TAIL_WORD) && !frame_bad);
            end
        end
    end

    always_ff @(posedge bus_clk) begin
        if (!rst_n) begin
            state        <= HUNT;
            idx          <= 8'd0;
            frame_bad    <= 1'b0;
            frame_done   <= 1'b0;
            frame_good   <= 1'b0;
            in_sync      <= 1'b0;
            led_activity <= 1'b0;
        end else begin
            frame_done   <= 1'b0;
            frame_good   <= 1'b0;
            led_activity <= accept;
            if (abort_hit) begin
                state     <= HUNT;
                idx       <= 8'd0;
                frame_bad <= 1'b0;
                in_sync   <= 1'b0;
            end else if (accept) begin
                case (state)
                    HUNT: begin
                        if (wr.wr_data == HEAD_WORD) begin
                            state   <= PAYLOAD;
                            idx     <= 8'd1;
                            in_sync <= 1'b1;
                        end
                    end
                    PAYLOAD: begin
                        if (word_err_hit) begin
                            frame_bad <= 1'b1;
                        end
                        if (idx == LAST_IDX) begin
                            state <= TAIL;
                        end else begin
                            idx <= idx + 8'd1;
                        end
                    end
                    TAIL: begin
                        frame_done <= 1'b1;
                        frame_good <= ok_hit;
                        frame_bad  <= 1'b0;
                        state      <= HUNT;
                        idx        <= 8'd0;
                        in_sync    <= 1'b0;
                    end
                    default: begin
                        state   <= HUNT;
                        idx     <= 8'd0;
                        in_sync <= 1'b0;
                    end
                endcase
            end
        end
    end

    // A clear on the same edge as an increment leaves the counter at zero.
    always_ff @(posedge bus_clk) begin
        if (!rst_n || clr_stats) begin
            frame_ok_cnt  <= '0;
            frame_err_cnt <= '0;
            word_err_cnt  <= '0;
            abort_cnt     <= '0;
        end else begin
            if (ok_hit)       frame_ok_cnt  <= sat_inc(frame_ok_cnt);
            if (err_hit)      frame_err_cnt <= sat_inc(frame_err_cnt);
            if (word_err_hit) word_err_cnt  <= sat_inc(word_err_cnt);
            if (abort_hit)    abort_cnt     <= sat_inc(abort_cnt);
        end
    end

    always_ff @(posedge bus_clk) begin
        if (!rst_n) begin
            last_err_idx <= 8'd0;
        end else if (word_err_hit) begin
            last_err_idx <= idx;
        end
    end

endmodule

// File: tb/tb_frame_checker_32.sv
// Bench for frame_checker_32: a queue-based frame model checked every cycle against
// a 32-bit-counter instance and a 4-bit-counter instance fed the same stream.
module tb_frame_checker_32;

    localparam int          P    = 24;
    localparam logic [31:0] HEAD = 32'hAAAAAAAA;
    localparam logic [31:0] TAIL = 32'hF0F0F0F0;

    logic        bus_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic        en      = 1'b0;
    logic [31:0] data    = 32'd0;
    logic        open    = 1'b1;
    logic        clr     = 1'b0;

    always #5 bus_clk = ~bus_clk;

    frame_checker_32_if bus_a ();
    frame_checker_32_if bus_b ();
    assign bus_a.wr_en   = en;
    assign bus_a.wr_data = data;
    assign bus_a.wr_open = open;
    assign bus_b.wr_en   = en;
    assign bus_b.wr_data = data;
    assign bus_b.wr_open = open;

    logic [31:0] a_ok, a_err, a_werr, a_abort;
    logic [3:0]  b_ok, b_err, b_werr, b_abort;
    logic [7:0]  a_last, b_last;
    logic        a_done, a_good, a_sync, a_led;
    logic        b_done, b_good, b_sync, b_led;

    frame_checker_32 #(.CNT_W(32)) dut_a (
        .bus_clk(bus_clk), .rst_n(rst_n), .wr(bus_a), .clr_stats(clr),
        .frame_ok_cnt(a_ok), .frame_err_cnt(a_err), .word_err_cnt(a_werr),
        .abort_cnt(a_abort), .last_err_idx(a_last), .frame_done(a_done),
        .frame_good(a_good), .in_sync(a_sync), .led_activity(a_led)
    );

    frame_checker_32 #(.CNT_W(4)) dut_b (
        .bus_clk(bus_clk), .rst_n(rst_n), .wr(bus_b), .clr_stats(clr),
        .frame_ok_cnt(b_ok), .frame_err_cnt(b_err), .word_err_cnt(b_werr),
        .abort_cnt(b_abort), .last_err_idx(b_last), .frame_done(b_done),
        .frame_good(b_good), .in_sync(b_sync), .led_activity(b_led)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int done_seen = 0;
    int good_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pat(input int n);
        logic [15:0] hi, lo;
        lo = 16'(2 * n);
        hi = 16'(2 * n - 1);
        return {hi, lo};
    endfunction

    function automatic logic [63:0] sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return 64'((v > mx) ? mx : v);
    endfunction

    // Reference model: collects the words following a head and judges the frame as a whole.
    longint      m_ok = 0, m_err = 0, m_werr = 0, m_abort = 0;
    logic [7:0]  m_last = 8'd0;
    bit          m_done = 0, m_good = 0, m_sync = 0, m_led = 0;
    bit          in_frame = 0;
    logic [31:0] q[$];

    task automatic model_step();
        bit good;
        int n;
        if (!rst_n) begin
            m_ok = 0; m_err = 0; m_werr = 0; m_abort = 0; m_last = 8'd0;
            m_done = 0; m_good = 0; m_led = 0;
            in_frame = 0;
            q.delete();
        end else begin
            m_done = 0;
            m_good = 0;
            m_led  = en;
            if (in_frame && !open) begin
                m_abort++;
                in_frame = 0;
                q.delete();
            end else if (en) begin
                if (!in_frame) begin
                    in_frame = (data == HEAD);
                end else begin
                    q.push_back(data);
                    n = q.size();
                    if (n <= P) begin
                        if (data != pat(n)) begin
                            m_werr++;
                            m_last = 8'(n);
                        end
                    end else begin
                        good = (data == TAIL);
                        for (int i = 1; i <= P; i++)
                            if (q[i-1] != pat(i)) good = 0;
                        if (good) m_ok++; else m_err++;
                        m_done = 1;
                        m_good = good;
                        in_frame = 0;
                        q.delete();
                    end
                end
            end
            if (clr) begin
                m_ok = 0; m_err = 0; m_werr = 0; m_abort = 0;
            end
        end
        m_sync = in_frame;
    endtask

    initial forever begin
        @(posedge bus_clk);
        model_step();
    end

    initial forever begin
        @(posedge bus_clk);
        #2;
        chk("a_wr_full", bus_a.wr_full, !rst_n);
        chk("b_wr_full", bus_b.wr_full, !rst_n);
        chk("a_ok", a_ok, sat(m_ok, 32));
        chk("a_err", a_err, sat(m_err, 32));
        chk("a_werr", a_werr, sat(m_werr, 32));
        chk("a_abort", a_abort, sat(m_abort, 32));
        chk("b_ok", b_ok, sat(m_ok, 4));
        chk("b_err", b_err, sat(m_err, 4));
        chk("b_werr", b_werr, sat(m_werr, 4));
        chk("b_abort", b_abort, sat(m_abort, 4));
        chk("a_last", a_last, m_last);
        chk("b_last", b_last, m_last);
        chk("a_done", a_done, m_done);
        chk("b_done", b_done, m_done);
        chk("a_sync", a_sync, m_sync);
        chk("b_sync", b_sync, m_sync);
        chk("a_led", a_led, m_led);
        chk("b_led", b_led, m_led);
        if (m_done) begin
            chk("a_good", a_good, m_good);
            chk("b_good", b_good, m_good);
        end
        if (a_done) done_seen++;
        if (a_done && a_good) good_seen++;
    end

    task automatic put(input logic [31:0] w, input int gap_max, input bit rnd);
        int g;
        g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        repeat (g) begin
            @(negedge bus_clk);
            en = 1'b0; data = $urandom; clr = 1'b0; open = 1'b1;
        end
        if (rnd && $urandom_range(31, 0) == 0) begin
            @(negedge bus_clk);
            open = 1'b0; en = 1'($urandom_range(1, 0)); data = $urandom; clr = 1'b0;
        end
        @(negedge bus_clk);
        open = 1'b1; en = 1'b1; data = w;
        clr = rnd && ($urandom_range(63, 0) == 0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge bus_clk);
            en = 1'b0; clr = 1'b0; open = 1'b1;
        end
    endtask

    task automatic clear_stats();
        @(negedge bus_clk);
        en = 1'b0; clr = 1'b1; open = 1'b1;
        @(negedge bus_clk);
        clr = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] tail, input int bad_idx,
                              input logic [31:0] bad_val, input int gap_max);
        put(HEAD, gap_max, 1'b0);
        for (int i = 1; i <= P; i++)
            put((i == bad_idx) ? bad_val : pat(i), gap_max, 1'b0);
        put(tail, gap_max, 1'b0);
    endtask

    initial begin
        int d0;
        int mode, gap;
        logic [31:0] w;

        rst_n = 1'b0;
        repeat (3) @(negedge bus_clk);
        chk("reset_wr_full", bus_a.wr_full, 1'b1);
        chk("reset_ok", a_ok, 0);
        chk("reset_sync", a_sync, 1'b0);
        rst_n = 1'b1;
        idle(2);
        chk("run_wr_full", bus_a.wr_full, 1'b0);

        // Good frame, wr_en held high
        send_frame(TAIL, 0, 32'd0, 0);
        idle(3);
        chk("good_ok", a_ok, 1);
        chk("good_err", a_err, 0);
        chk("good_werr", a_werr, 0);
        chk("good_abort", a_abort, 0);
        chk("good_done_pulses", done_seen, 1);
        chk("good_good_pulses", good_seen, 1);

        // Corrupt payload at idx 5
        clear_stats();
        send_frame(TAIL, 5, 32'h00090000, 0);
        idle(3);
        chk("corrupt_werr", a_werr, 1);
        chk("corrupt_last", a_last, 5);
        chk("corrupt_err", a_err, 1);
        chk("corrupt_ok", a_ok, 0);
        chk("corrupt_good_pulses", good_seen, 1);

        // Garbage, bad tail, then a good frame back to back
        clear_stats();
        repeat (3) put(32'h12345678, 0, 1'b0);
        idle(1);
        chk("garbage_sync", a_sync, 1'b0);
        send_frame(32'hF0F0F0F1, 0, 32'd0, 0);
        send_frame(TAIL, 0, 32'd0, 0);
        idle(3);
        chk("resync_err", a_err, 1);
        chk("resync_ok", a_ok, 1);

        // Abort after head and 10 payload words
        clear_stats();
        d0 = done_seen;
        put(HEAD, 0, 1'b0);
        for (int i = 1; i <= 10; i++) put(pat(i), 0, 1'b0);
        @(negedge bus_clk);
        en = 1'b0; open = 1'b0;
        repeat (2) @(negedge bus_clk);
        chk("abort_cnt", a_abort, 1);
        chk("abort_sync", a_sync, 1'b0);
        chk("abort_no_done", done_seen, d0);
        open = 1'b1;
        send_frame(TAIL, 0, 32'd0, 0);
        idle(3);
        chk("abort_then_ok", a_ok, 1);
        chk("abort_single", a_abort, 1);

        // Idle gaps inside a frame
        clear_stats();
        send_frame(TAIL, 0, 32'd0, 3);
        idle(3);
        chk("gaps_ok", a_ok, 1);
        chk("gaps_err", a_err + a_werr, 0);

        // Saturation on the 4-bit instance, then clear coinciding with a tail accept
        clear_stats();
        repeat (17) send_frame(TAIL, 0, 32'd0, 0);
        idle(2);
        chk("sat_b_ok", b_ok, 15);
        chk("sat_a_ok", a_ok, 17);
        put(HEAD, 0, 1'b0);
        for (int i = 1; i <= P; i++) put(pat(i), 0, 1'b0);
        put(TAIL, 0, 1'b0);
        clr = 1'b1;
        idle(1);
        chk("clr_wins_b", b_ok, 0);
        chk("clr_wins_a", a_ok, 0);

        // Reset mid-frame does not count as an abort
        put(HEAD, 0, 1'b0);
        for (int i = 1; i <= 5; i++) put(pat(i), 0, 1'b0);
        @(negedge bus_clk);
        rst_n = 1'b0; en = 1'b0;
        repeat (2) @(negedge bus_clk);
        chk("rst_mid_abort", a_abort, 0);
        chk("rst_mid_sync", a_sync, 1'b0);
        rst_n = 1'b1;
        idle(2);

        // Randomized traffic
        for (int f = 0; f < 250; f++) begin
            mode = int'($urandom_range(9, 0));
            gap  = ($urandom_range(1, 0) == 1) ? 2 : 0;
            if (mode == 0)
                repeat ($urandom_range(3, 1)) put($urandom, gap, 1'b1);
            put(HEAD, gap, 1'b1);
            for (int i = 1; i <= P; i++) begin
                w = pat(i);
                if (mode == 1 && $urandom_range(7, 0) == 0) w = $urandom;
                if (mode == 2 && i == 3) w = HEAD;
                put(w, gap, mode >= 4);
            end
            put((mode == 3) ? (TAIL ^ 32'h1) : TAIL, gap, mode >= 4);
            if ($urandom_range(7, 0) == 0) idle(int'($urandom_range(3, 1)));
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
